ctrlwd_pipe: RTL and testbench

Carries the decoded 58-bit control word from the decode-stage control LUT through the ID/EX, EX/MEM and MEM/WB pipeline registers. At each stage it presents the field slice that stage consumes. Handles load-use stall bubbles, branch flush and global freeze, and keeps a retired-instruction counter. It sits between the control LUT output and the datapath stage muxes, so it is the receiving end of the control-word interface.

---
 rtl/ctrlwd_pipe_pkg.sv | 19 +
 rtl/ctrlwd_pipe_if.sv | 34 +++
 rtl/ctrlwd_pipe_stage_reg.sv | 31 +++
 rtl/ctrlwd_pipe.sv | 77 +++++++
 tb/tb_ctrlwd_pipe.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrlwd_pipe_pkg.sv
// Shared control-word geometry for the decoder and the control pipeline.
// The field layout is {EX, MEM, WB} from MSB to LSB.
package ctrl_pkg;

    localparam int CW_W  = 58;
    localparam int WB_W  = 8;
    localparam int MEM_W = 12;
    localparam int EX_W  = CW_W - MEM_W - WB_W;

    localparam int WB_LSB  = 0;
    localparam int MEM_LSB = WB_W;
    localparam int EX_LSB  = WB_W + MEM_W;

    localparam int RETIRE_CNT_W = 32;

    // A bubble is all-zero control: no register write, no memory access.
    localparam logic [CW_W-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrlwd_pipe_if.sv
// Control-word bus between the decode-stage LUT (master) and the pipeline (slave).
// in_valid qualifies ctrl_wrd for one cycle; there is no ready: freeze, stall and flush are the only holds.
interface ctrlwd_pipe_if
    import ctrl_pkg::*;
#(
    parameter int CNT_W = RETIRE_CNT_W
);

    logic [CW_W-1:0]  ctrl_wrd;
    logic             in_valid;
    logic             stall;
    logic             flush;
    logic             freeze;
    logic             cnt_clr;

    logic [EX_W-1:0]  ctrl_ex;
    logic [MEM_W-1:0] ctrl_mem;
    logic [WB_W-1:0]  ctrl_wb;
    logic             valid_ex;
    logic             valid_mem;
    logic             valid_wb;
    logic [CNT_W-1:0] retire_cnt;

    modport master (
        output ctrl_wrd, in_valid, stall, flush, freeze, cnt_clr,
        input  ctrl_ex, ctrl_mem, ctrl_wb, valid_ex, valid_mem, valid_wb, retire_cnt
    );

    modport slave (
        input  ctrl_wrd, in_valid, stall, flush, freeze, cnt_clr,
        output ctrl_ex, ctrl_mem, ctrl_wb, valid_ex, valid_mem, valid_wb, retire_cnt
    );

endinterface

// File: rtl/ctrlwd_pipe_stage_reg.sv
// One pipeline stage register holding {ctrl slice, valid}.
// Priority: hold > bubble > load; loading an invalid word stores zeros so no stale field survives.
module ctrl_stage_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         hold,
    input  logic         bubble,
    input  logic [W-1:0] d,
    input  logic         d_valid,
    output logic [W-1:0] q,
    output logic         q_valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else if (!hold) begin
            if (bubble || !d_valid) begin
                q       <= '0;
                q_valid <= 1'b0;
            end else begin
                q       <= d;
                q_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ctrlwd_pipe.sv
// Carries the decoded control word through ID/EX, EX/MEM and MEM/WB and counts retirements.
// Every output is a register bit; no input reaches an output combinationally.
module ctrlwd_pipe
    import ctrl_pkg::*;
#(
    parameter int CNT_W = RETIRE_CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    ctrlwd_pipe_if.slave bus
);

    logic [CW_W-1:0]   idex_q;
    logic              idex_v;
    logic [EX_LSB-1:0] exmem_q;
    logic              exmem_v;
    logic [WB_W-1:0]   memwb_q;
    logic              memwb_v;
    logic [CNT_W-1:0]  retire_cnt_q;
    logic              insert_bubble;

    // Stall and flush both squash only the word entering ID/EX; older stages keep draining.
    assign insert_bubble = bus.stall | bus.flush;

    ctrl_stage_reg #(.W(CW_W)) u_idex (
        .clk     (clk),
        .rst_n   (rst_n),
        .hold    (bus.freeze),
        .bubble  (insert_bubble),
        .d       (bus.ctrl_wrd),
        .d_valid (bus.in_valid),
        .q       (idex_q),
        .q_valid (idex_v)
    );

    ctrl_stage_reg #(.W(EX_LSB)) u_exmem (
        .clk     (clk),
        .rst_n   (rst_n),
        .hold    (bus.freeze),
        .bubble  (1'b0),
        .d       (idex_q[EX_LSB-1:0]),
        .d_valid (idex_v),
        .q       (exmem_q),
        .q_valid (exmem_v)
    );

    ctrl_stage_reg #(.W(WB_W)) u_memwb (
        .clk     (clk),
        .rst_n   (rst_n),
        .hold    (bus.freeze),
        .bubble  (1'b0),
        .d       (exmem_q[WB_W-1:0]),
        .d_valid (exmem_v),
        .q       (memwb_q),
        .q_valid (memwb_v)
    );

    // Clear beats increment; a frozen MEM/WB entry has not retired yet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_q <= '0;
        end else if (bus.cnt_clr) begin
            retire_cnt_q <= '0;
        end else if (memwb_v && !bus.freeze) begin
            retire_cnt_q <= retire_cnt_q + 1'b1;
        end
    end

    assign bus.ctrl_ex    = idex_q[CW_W-1:EX_LSB];
    assign bus.ctrl_mem   = exmem_q[EX_LSB-1:MEM_LSB];
    assign bus.ctrl_wb    = memwb_q[WB_LSB +: WB_W];
    assign bus.valid_ex   = idex_v;
    assign bus.valid_mem  = exmem_v;
    assign bus.valid_wb   = memwb_v;
    assign bus.retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_ctrlwd_pipe.sv
// Bench for ctrlwd_pipe: directed vector table, random run against a history-queue model, async reset.
// A second instance with a 4-bit counter exposes counter wrap in a short run.
module tb_ctrlwd_pipe;
    import ctrl_pkg::*;

    logic clk;
    logic rst_n;

    ctrlwd_pipe_if #(.CNT_W(32)) bus ();
    ctrlwd_pipe_if #(.CNT_W(4))  bus_w ();

    ctrlwd_pipe #(.CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    ctrlwd_pipe #(.CNT_W(4)) dut_w (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_w)
    );

    assign bus_w.ctrl_wrd = bus.ctrl_wrd;
    assign bus_w.in_valid = bus.in_valid;
    assign bus_w.stall    = bus.stall;
    assign bus_w.flush    = bus.flush;
    assign bus_w.freeze   = bus.freeze;
    assign bus_w.cnt_clr  = bus.cnt_clr;

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    // Entries are {valid, word}; index 0 = MEM/WB, 1 = EX/MEM, 2 = ID/EX.
    logic [CW_W:0] exp_q[$];
    logic [31:0]   m_cnt;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic reset_model();
        exp_q.delete();
        repeat (3) exp_q.push_back('0);
        m_cnt = '0;
    endtask

    task automatic model_edge(input logic [CW_W-1:0] w, input logic v, input logic st,
                              input logic fl, input logic fz, input logic clr);
        logic [CW_W:0] ent;
        if (!fz) begin
            if (exp_q[0][CW_W]) m_cnt = m_cnt + 32'd1;
            ent = (st || fl || !v) ? '0 : {1'b1, w};
            exp_q.push_back(ent);
            void'(exp_q.pop_front());
        end
        if (clr) m_cnt = '0;
    endtask

    task automatic check_model(input string tag);
        logic [CW_W:0] e_ex;
        logic [CW_W:0] e_mem;
        logic [CW_W:0] e_wb;
        logic [3:0]    cnt_small;
        e_wb  = exp_q[0];
        e_mem = exp_q[1];
        e_ex  = exp_q[2];
        cnt_small = m_cnt[3:0];
        chk({tag, " ctrl_ex"},   64'(bus.ctrl_ex),   64'(e_ex[CW_W-1:EX_LSB]));
        chk({tag, " valid_ex"},  64'(bus.valid_ex),  64'(e_ex[CW_W]));
        chk({tag, " ctrl_mem"},  64'(bus.ctrl_mem),  64'(e_mem[EX_LSB-1:MEM_LSB]));
        chk({tag, " valid_mem"}, 64'(bus.valid_mem), 64'(e_mem[CW_W]));
        chk({tag, " ctrl_wb"},   64'(bus.ctrl_wb),   64'(e_wb[WB_W-1:0]));
        chk({tag, " valid_wb"},  64'(bus.valid_wb),  64'(e_wb[CW_W]));
        chk({tag, " retire_cnt"},   64'(bus.retire_cnt),   64'(m_cnt));
        chk({tag, " retire_cnt_w"}, 64'(bus_w.retire_cnt), 64'(cnt_small));
    endtask

    // ---------------- driver ----------------
    task automatic step(input string tag, input logic [CW_W-1:0] w, input logic v, input logic st,
                        input logic fl, input logic fz, input logic clr);
        bus.ctrl_wrd = w;
        bus.in_valid = v;
        bus.stall    = st;
        bus.flush    = fl;
        bus.freeze   = fz;
        bus.cnt_clr  = clr;
        @(posedge clk);
        model_edge(w, v, st, fl, fz, clr);
        @(negedge clk);
        check_model(tag);
    endtask

    function automatic logic [CW_W-1:0] cw(input logic [EX_W-1:0] ex, input logic [MEM_W-1:0] mem,
                                           input logic [WB_W-1:0] wb);
        return {ex, mem, wb};
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [CW_W-1:0]  w;
        logic             v, st, fl, fz, clr;
        logic [EX_W-1:0]  ex;
        logic             vex;
        logic [MEM_W-1:0] mem;
        logic             vmem;
        logic [WB_W-1:0]  wb;
        logic             vwb;
        logic [31:0]      cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [CW_W-1:0] w, input logic v, input logic st, input logic fl,
                       input logic fz, input logic clr, input logic [EX_W-1:0] ex, input logic vex,
                       input logic [MEM_W-1:0] mem, input logic vmem, input logic [WB_W-1:0] wb,
                       input logic vwb, input logic [31:0] cnt);
        vec_t t;
        t.w = w; t.v = v; t.st = st; t.fl = fl; t.fz = fz; t.clr = clr;
        t.ex = ex; t.vex = vex; t.mem = mem; t.vmem = vmem; t.wb = wb; t.vwb = vwb; t.cnt = cnt;
        tbl.push_back(t);
    endtask

    initial begin
        logic [CW_W-1:0]  ones_w;
        logic [EX_W-1:0]  ones_ex;
        logic [MEM_W-1:0] ones_mem;
        logic [CW_W-1:0]  wa, wb_, wc, wd, we, wf, wg, wh, wy;
        logic [63:0]      r64;
        string            nm;

        ones_w   = '1;
        ones_ex  = '1;
        ones_mem = '1;
        wa = cw(38'h11, 12'h111, 8'h11);
        wb_ = cw(38'h22, 12'h222, 8'h22);
        wc = cw(38'h33, 12'h333, 8'h33);
        wd = cw(38'h44, 12'h444, 8'h44);
        we = cw(38'h55, 12'h555, 8'h55);
        wf = cw(38'h66, 12'h666, 8'h66);
        wg = cw(38'h12, 12'h121, 8'h12);
        wh = cw(38'h77, 12'h777, 8'h77);
        wy = cw(38'h5A, 12'h5A5, 8'hA5);

        //    word    v  st fl fz clr  ex          vex mem         vmem wb     vwb cnt
        add(ones_w,  1, 0, 0, 0, 0,   ones_ex,    1,  12'h0,      0,   8'h0,  0,  0);
        add('0,      0, 0, 0, 0, 0,   38'h0,      0,  ones_mem,   1,   8'h0,  0,  0);
        add('0,      0, 0, 0, 0, 0,   38'h0,      0,  12'h0,      0,   8'hFF, 1,  0);
        add('0,      0, 0, 0, 0, 0,   38'h0,      0,  12'h0,      0,   8'h0,  0,  1);
        add(wa,      1, 0, 0, 0, 0,   38'h11,     1,  12'h0,      0,   8'h0,  0,  1);
        add(wb_,     1, 1, 0, 0, 0,   38'h0,      0,  12'h111,    1,   8'h0,  0,  1);
        add(wc,      1, 0, 0, 0, 0,   38'h33,     1,  12'h0,      0,   8'h11, 1,  1);
        add('0,      0, 0, 0, 0, 0,   38'h0,      0,  12'h333,    1,   8'h0,  0,  2);
        add('0,      0, 0, 0, 0, 0,   38'h0,      0,  12'h0,      0,   8'h33, 1,  2);
        add('0,      0, 0, 0, 0, 0,   38'h0,      0,  12'h0,      0,   8'h0,  0,  3);
        add(wd,      1, 0, 0, 0, 0,   38'h44,     1,  12'h0,      0,   8'h0,  0,  3);
        add(we,      1, 0, 1, 1, 0,   38'h44,     1,  12'h0,      0,   8'h0,  0,  3);
        add(we,      1, 0, 1, 0, 0,   38'h0,      0,  12'h444,    1,   8'h0,  0,  3);
        add('0,      0, 0, 0, 0, 0,   38'h0,      0,  12'h0,      0,   8'h44, 1,  3);
        add('0,      0, 0, 0, 0, 1,   38'h0,      0,  12'h0,      0,   8'h0,  0,  0);
        add(wf,      1, 0, 0, 0, 0,   38'h66,     1,  12'h0,      0,   8'h0,  0,  0);
        add(wg,      1, 1, 1, 0, 0,   38'h0,      0,  12'h666,    1,   8'h0,  0,  0);
        add('0,      0, 0, 0, 0, 0,   38'h0,      0,  12'h0,      0,   8'h66, 1,  0);
        add('0,      0, 0, 0, 0, 0,   38'h0,      0,  12'h0,      0,   8'h0,  0,  1);
        add(ones_w,  0, 0, 0, 0, 0,   38'h0,      0,  12'h0,      0,   8'h0,  0,  1);
        add(wh,      1, 0, 0, 0, 0,   38'h77,     1,  12'h0,      0,   8'h0,  0,  1);
        for (int i = 0; i < 4; i++)
            add(ones_w, 1, 1, 0, 1, 0, 38'h77,    1,  12'h0,      0,   8'h0,  0,  1);
        add('0,      0, 0, 0, 0, 0,   38'h0,      0,  12'h777,    1,   8'h0,  0,  1);
        add('0,      0, 0, 0, 0, 0,   38'h0,      0,  12'h0,      0,   8'h77, 1,  1);
        add('0,      0, 0, 0, 1, 0,   38'h0,      0,  12'h0,      0,   8'h77, 1,  1);
        add('0,      0, 0, 0, 1, 0,   38'h0,      0,  12'h0,      0,   8'h77, 1,  1);
        add('0,      0, 0, 0, 0, 0,   38'h0,      0,  12'h0,      0,   8'h0,  0,  2);

        // ---------------- reset ----------------
        rst_n        = 1'b0;
        bus.ctrl_wrd = '0;
        bus.in_valid = 1'b0;
        bus.stall    = 1'b0;
        bus.flush    = 1'b0;
        bus.freeze   = 1'b0;
        bus.cnt_clr  = 1'b0;
        reset_model();
        repeat (3) @(negedge clk);
        chk("reset ctrl_ex",    64'(bus.ctrl_ex),    64'h0);
        chk("reset valid_ex",   64'(bus.valid_ex),   64'h0);
        chk("reset ctrl_mem",   64'(bus.ctrl_mem),   64'h0);
        chk("reset valid_mem",  64'(bus.valid_mem),  64'h0);
        chk("reset ctrl_wb",    64'(bus.ctrl_wb),    64'h0);
        chk("reset valid_wb",   64'(bus.valid_wb),   64'h0);
        chk("reset retire_cnt", 64'(bus.retire_cnt), 64'h0);
        rst_n = 1'b1;

        // ---------------- directed table ----------------
        foreach (tbl[i]) begin
            nm = $sformatf("vec%0d", i);
            step(nm, tbl[i].w, tbl[i].v, tbl[i].st, tbl[i].fl, tbl[i].fz, tbl[i].clr);
            chk({nm, " tbl ctrl_ex"},    64'(bus.ctrl_ex),    64'(tbl[i].ex));
            chk({nm, " tbl valid_ex"},   64'(bus.valid_ex),   64'(tbl[i].vex));
            chk({nm, " tbl ctrl_mem"},   64'(bus.ctrl_mem),   64'(tbl[i].mem));
            chk({nm, " tbl valid_mem"},  64'(bus.valid_mem),  64'(tbl[i].vmem));
            chk({nm, " tbl ctrl_wb"},    64'(bus.ctrl_wb),    64'(tbl[i].wb));
            chk({nm, " tbl valid_wb"},   64'(bus.valid_wb),   64'(tbl[i].vwb));
            chk({nm, " tbl retire_cnt"}, 64'(bus.retire_cnt), 64'(tbl[i].cnt));
        end

        // ---------------- random run ----------------
        for (int i = 0; i < 600; i++) begin
            r64 = {$urandom, $urandom};
            step($sformatf("rnd%0d", i), r64[CW_W-1:0],
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 99) < 12),
                 ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 15),
                 ($urandom_range(0, 99) < 2));
        end

        // ---------------- async reset mid-stream ----------------
        step("pre_rst0", wa, 1, 0, 0, 0, 0);
        step("pre_rst1", wc, 1, 0, 0, 0, 0);
        step("pre_rst2", wd, 1, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async valid_ex",   64'(bus.valid_ex),   64'h0);
        chk("async valid_mem",  64'(bus.valid_mem),  64'h0);
        chk("async valid_wb",   64'(bus.valid_wb),   64'h0);
        chk("async ctrl_ex",    64'(bus.ctrl_ex),    64'h0);
        chk("async retire_cnt", 64'(bus.retire_cnt), 64'h0);
        reset_model();
        check_model("async");
        @(negedge clk);
        check_model("in_rst");
        rst_n = 1'b1;
        step("post_rst", wy, 1, 0, 0, 0, 0);
        chk("post_rst ctrl_ex",  64'(bus.ctrl_ex),  64'h5A);
        chk("post_rst valid_ex", 64'(bus.valid_ex), 64'h1);
        step("post_rst1", '0, 0, 0, 0, 0, 0);
        step("post_rst2", '0, 0, 0, 0, 0, 0);
        step("post_rst3", '0, 0, 0, 0, 0, 0);
        chk("post_rst retire_cnt", 64'(bus.retire_cnt), 64'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
